// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame encodings, receiver state type and helpers
package uart_pkg;
  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;
  localparam logic PAR_ODD = 1'b0;
  localparam logic PAR_EVEN = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
  typedef struct packed {
    logic [1:0] dbits;
    logic       par_en;
    logic       par_type;
    logic       stop2;
  } rx_cfg_t;
  function automatic logic [3:0] num_data_bits(input logic [1:0] d);
    return 4'd5 + {2'b00, d};
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: register-block side of the UART receiver
interface uart_rx_if;
  logic [1:0] data_bit_num_i;
  logic       parity_en_i;
  logic       parity_type_i;
  logic       stop_bit_num_i;
  logic       rx_read_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_err_o;
  modport slave (
    input  data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i, rx_read_i,
    output rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_err_o
  );
  modport master (
    output data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i, rx_read_i,
    input  rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_err_o
  );
endinterface

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for an idle-high asynchronous input
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk) ff <= rst ? '1 : {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with parity/framing/overrun status
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_tick,
  input  logic       rx,
  output logic       rts_n,
  uart_rx_if.slave   bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  logic rx_s;
  rx_state_e state, state_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n;
  logic perr, perr_n, ferr, ferr_n, stop_cnt, stop_n, hold, hold_n, done, at_bit;
  rx_cfg_t cfg, cfg_n;
  logic [7:0] data_q;
  logic valid_q, perr_q, ferr_q, ovr_q;
  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
  assign at_bit = tick_cnt == LAST;
  always_comb begin
    state_n = state;
    tick_n = tick_cnt;
    bit_n = bit_cnt;
    shift_n = shift;
    perr_n = perr;
    ferr_n = ferr;
    stop_n = stop_cnt;
    cfg_n = cfg;
    hold_n = hold;
    done = 1'b0;
    if (rx_tick) begin
      tick_n = at_bit ? '0 : tick_cnt + 1'b1;
      case (state)
        IDLE: begin
          hold_n = hold & ~rx_s;
          if (!hold && !rx_s) begin
            state_n = START;
            tick_n = '0;
            cfg_n = {bus.data_bit_num_i, bus.parity_en_i, bus.parity_type_i, bus.stop_bit_num_i};
            shift_n = '0;
            perr_n = 1'b0;
            ferr_n = 1'b0;
            stop_n = 1'b0;
          end
        end
        START: if (tick_cnt == MID) begin
          state_n = rx_s ? IDLE : DATA;
          tick_n = '0;
          bit_n = '0;
        end
        DATA: if (at_bit) begin
          shift_n[bit_cnt] = rx_s;
          bit_n = bit_cnt + 1'b1;
          if ({1'b0, bit_cnt} == num_data_bits(cfg.dbits) - 4'd1) state_n = cfg.par_en ? PARITY : STOP;
        end
        PARITY: if (at_bit) begin
          perr_n = rx_s != ((cfg.par_type == PAR_EVEN) ? ^shift : ~^shift);
          state_n = STOP;
        end
        STOP: if (at_bit) begin
          ferr_n = ferr | ~rx_s;
          stop_n = 1'b1;
          // a low final stop sample may be a break; wait for the line to idle before re-arming
          if (stop_cnt == cfg.stop2) begin
            done = 1'b1;
            state_n = IDLE;
            hold_n = ~rx_s;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
      stop_cnt <= 1'b0;
      cfg <= '0;
      hold <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state <= state_n;
      tick_cnt <= tick_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      perr <= perr_n;
      ferr <= ferr_n;
      stop_cnt <= stop_n;
      cfg <= cfg_n;
      hold <= hold_n;
      if (done) begin
        data_q <= shift_n;
        perr_q <= perr_n;
        ferr_q <= ferr_n;
        valid_q <= 1'b1;
        if (valid_q && !bus.rx_read_i) ovr_q <= 1'b1;
      end else if (bus.rx_read_i) begin
        valid_q <= 1'b0;
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
        if (valid_q) ovr_q <= 1'b0;
      end
    end
  end
  assign bus.rx_data_o = data_q;
  assign bus.rx_valid_o = valid_q;
  assign bus.parity_err_o = perr_q;
  assign bus.frame_err_o = ferr_q;
  assign bus.overrun_err_o = ovr_q;
  assign rts_n = valid_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus checked against a frame-level receiver model
module tb_uart_rx;
  import uart_pkg::*;
  localparam int OS = 16, TPB = 4, BIT = OS * TPB;
  logic clk = 1'b0, rst = 1'b1, rx_tick = 1'b0, rx = 1'b1;
  logic rts_n;
  int errors = 0, checks = 0;
  logic live = 1'b0;
  logic ev = 1'b0, ep = 1'b0, ef = 1'b0, eo = 1'b0;
  logic [7:0] ed = '0;
  uart_rx_if bus();
  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx_tick(rx_tick), .rx(rx), .rts_n(rts_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  initial forever begin
    repeat (TPB - 1) @(negedge clk) rx_tick = 1'b0;
    @(negedge clk) rx_tick = 1'b1;
  end
  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  // model of the register-visible state, updated only at frame/read boundaries
  always @(negedge clk) if (live && !rst) begin
    checks++;
    if ({bus.rx_valid_o, rts_n, bus.parity_err_o, bus.frame_err_o, bus.overrun_err_o} !== {ev, ev, ep, ef, eo}
        || (ev && bus.rx_data_o !== ed)) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got v=%b rts_n=%b d=%h pe=%b fe=%b ov=%b exp v=%b d=%h pe=%b fe=%b ov=%b",
               $time, bus.rx_valid_o, rts_n, bus.rx_data_o, bus.parity_err_o, bus.frame_err_o,
               bus.overrun_err_o, ev, ed, ep, ef, eo);
    end
  end
  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic model_frame(input logic [7:0] d, input logic p, input logic f);
    if (ev) eo = 1'b1;
    ev = 1'b1;
    ed = d;
    ep = p;
    ef = f;
  endtask
  task automatic model_read;
    if (ev) eo = 1'b0;
    ev = 1'b0;
    ep = 1'b0;
    ef = 1'b0;
  endtask
  task automatic hold_bit(input int bc);
    repeat (bc) @(negedge clk);
  endtask
  task automatic do_read;
    live = 1'b0;
    @(negedge clk) bus.rx_read_i = 1'b1;
    @(negedge clk) bus.rx_read_i = 1'b0;
    model_read();
    live = 1'b1;
  endtask
  task automatic send(input logic [1:0] db, input logic pe, input logic pt, input logic s2,
                      input logic [7:0] din, input logic pbad, input logic [1:0] sbad, input int bc);
    int nb;
    logic [7:0] d;
    logic pb;
    nb = 5 + int'(db);
    d = din & (8'hFF >> (8 - nb));
    pb = (pt ? ^d : ~^d) ^ pbad;
    bus.data_bit_num_i = db;
    bus.parity_en_i = pe;
    bus.parity_type_i = pt;
    bus.stop_bit_num_i = s2;
    rx = 1'b0;
    hold_bit(bc);
    bus.data_bit_num_i = 2'($urandom);
    bus.parity_en_i = 1'($urandom);
    bus.parity_type_i = 1'($urandom);
    bus.stop_bit_num_i = 1'($urandom);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      hold_bit(bc);
    end
    if (pe) begin
      rx = pb;
      hold_bit(bc);
    end
    if (s2) begin
      rx = ~sbad[0];
      hold_bit(bc);
    end
    live = 1'b0;
    rx = s2 ? ~sbad[1] : ~sbad[0];
    hold_bit(bc);
    rx = 1'b1;
    model_frame(d, pe & pbad, sbad[0] | (s2 & sbad[1]));
    live = 1'b1;
  endtask
  initial begin
    bus.data_bit_num_i = DBITS_8;
    bus.parity_en_i = 1'b0;
    bus.parity_type_i = PAR_ODD;
    bus.stop_bit_num_i = 1'b0;
    bus.rx_read_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    chk("rst_data", bus.rx_data_o, 8'h00);
    chk("rst_valid", bus.rx_valid_o, 0);
    chk("rst_rts_n", rts_n, 0);
    chk("rst_errs", {bus.parity_err_o, bus.frame_err_o, bus.overrun_err_o}, 0);
    live = 1'b1;
    hold_bit(BIT);
    send(DBITS_8, 0, 0, 0, 8'hA5, 0, 2'b00, BIT);
    chk("a5_data", bus.rx_data_o, 8'hA5);
    chk("a5_valid", bus.rx_valid_o, 1);
    chk("a5_rts_n", rts_n, 1);
    chk("a5_errs", {bus.parity_err_o, bus.frame_err_o, bus.overrun_err_o}, 0);
    do_read();
    chk("a5_read_valid", bus.rx_valid_o, 0);
    chk("a5_read_rts_n", rts_n, 0);
    send(DBITS_7, 1, PAR_EVEN, 0, 8'h35, 0, 2'b00, BIT);
    chk("7e1_data", bus.rx_data_o, 8'h35);
    chk("7e1_perr_ok", bus.parity_err_o, 0);
    do_read();
    send(DBITS_7, 1, PAR_EVEN, 0, 8'h35, 1, 2'b00, BIT);
    chk("7e1_perr_bad", bus.parity_err_o, 1);
    do_read();
    send(DBITS_5, 0, 0, 1, 8'h1F, 0, 2'b10, BIT);
    chk("5n2_data", bus.rx_data_o, 8'h1F);
    chk("5n2_ferr", bus.frame_err_o, 1);
    hold_bit(BIT);
    do_read();
    rx = 1'b0;
    hold_bit(4 * TPB);
    rx = 1'b1;
    hold_bit(2 * BIT);
    chk("glitch_valid", bus.rx_valid_o, 0);
    send(DBITS_8, 0, 0, 0, 8'h3C, 0, 2'b00, BIT);
    chk("3c_data", bus.rx_data_o, 8'h3C);
    do_read();
    send(DBITS_8, 0, 0, 0, 8'h11, 0, 2'b00, BIT);
    send(DBITS_8, 0, 0, 0, 8'h22, 0, 2'b00, BIT);
    chk("ovr_data", bus.rx_data_o, 8'h22);
    chk("ovr_flag", bus.overrun_err_o, 1);
    do_read();
    chk("ovr_cleared", {bus.rx_valid_o, bus.parity_err_o, bus.frame_err_o, bus.overrun_err_o}, 0);
    bus.data_bit_num_i = DBITS_8;
    bus.parity_en_i = 1'b0;
    bus.stop_bit_num_i = 1'b0;
    live = 1'b0;
    rx = 1'b0;
    hold_bit(14 * BIT);
    rx = 1'b1;
    hold_bit(2 * BIT);
    model_frame(8'h00, 0, 1);
    live = 1'b1;
    chk("break_data", bus.rx_data_o, 8'h00);
    chk("break_ferr", bus.frame_err_o, 1);
    chk("break_ovr", bus.overrun_err_o, 0);
    do_read();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(2) != 0) do_read();
      send(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
           $urandom_range(3) == 0, ($urandom_range(4) == 0) ? 2'($urandom) : 2'b00, BIT);
      hold_bit(BIT * int'($urandom_range(1, 2)));
    end
    do_read();
    for (int n = 0; n < 4; n++) begin
      send(DBITS_8, 1, PAR_ODD, 0, 8'($urandom), 0, 2'b00, BIT * 97 / 100);
      do_read();
    end
    live = 1'b0;
    bus.parity_en_i = 1'b1;
    bus.parity_type_i = PAR_ODD;
    rx = 1'b0;
    hold_bit(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = 1'($urandom);
      hold_bit(BIT);
    end
    rst = 1'b1;
    rx = 1'b1;
    hold_bit(3);
    rst = 1'b0;
    ev = 1'b0; ep = 1'b0; ef = 1'b0; eo = 1'b0; ed = '0;
    chk("midrst_data", bus.rx_data_o, 8'h00);
    chk("midrst_flags", {bus.rx_valid_o, rts_n, bus.parity_err_o, bus.frame_err_o, bus.overrun_err_o}, 0);
    live = 1'b1;
    hold_bit(2 * BIT);
    send(DBITS_8, 1, PAR_ODD, 0, 8'h6D, 0, 2'b00, BIT);
    chk("postrst_data", bus.rx_data_o, 8'h6D);
    chk("postrst_errs", {bus.parity_err_o, bus.frame_err_o, bus.overrun_err_o}, 0);
    do_read();
    live = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's uart_tx. Sits between the rx pin and the register block.
- Recovers 5–8 data bits, LSB first, with optional parity and 1 or 2 stop bits. Oversamples on a baud-generator tick.
- Holds each received byte until the register block reads it. Drives rts_n for flow control.
- Reports parity, framing and overrun errors.

Parameters:
- OVERSAMPLE, 16, rx_tick pulses per bit period (even, >=8).
- SYNC_STAGES, 2, flops in the rx input synchronizer (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx_tick  in  1  one-clk pulse at OVERSAMPLE x baud, from the baudrate generator.
- data_bit_num_i  in  2  frame length: 00=5, 01=6, 10=7, 11=8 data bits.
- parity_en_i  in  1  a parity bit follows the data bits.
- parity_type_i  in  1  0=odd (parity bit = ~^data), 1=even (parity bit = ^data); matches uart_tx.
- stop_bit_num_i  in  1  0=one stop bit, 1=two stop bits.
- rx_read_i  in  1  one-clk pulse: the register block consumed rx_data_o.
- rx  in  1  serial input, asynchronous, idles high.
- rx_data_o  out  8  received data, zero-extended above the frame length.
- rx_valid_o  out  1  rx_data_o holds an unread frame.
- parity_err_o  out  1  parity status of the frame in rx_data_o.
- frame_err_o  out  1  framing status of the frame in rx_data_o.
- overrun_err_o  out  1  sticky; a frame completed while rx_valid_o=1.
- rts_n  out  1  active-low ready-to-send; equals rx_valid_o.

Behaviour:
- Reset:
  - Synchronizer flops = 1, state = IDLE, all counters = 0.
  - rx_data_o = 0, rx_valid_o = 0, all error outputs = 0, rts_n = 0.
- All state and counter updates happen only on clk cycles with rx_tick=1, except the read/clear logic, which runs every clk.
- A tick counter (tick_cnt) counts 0..OVERSAMPLE-1 within each bit period. Mid-bit is tick_cnt = OVERSAMPLE/2-1.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE: rx_s=0 on a tick -> START, tick_cnt=0. Latch data_bit_num_i, parity_en_i, parity_type_i and stop_bit_num_i into a config shadow used for the rest of the frame.
  - START: at mid-bit, rx_s=1 -> IDLE (false start, no flags). rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0.
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift bit [bit_cnt]. After the last data bit -> PARITY if parity is enabled, else STOP.
  - PARITY: sample once. Error if the sample differs from the expected parity over the received bits.
  - STOP: sample every OVERSAMPLE ticks, 1 or 2 times. A sample of 0 sets the frame error. After the final stop sample -> COMPLETE, then IDLE on the same tick. The next start edge can therefore be detected half a bit early, which tolerates receive clock drift.
- COMPLETE, one clk:
  - rx_data_o = shift register, zero-extended.
  - parity_err_o and frame_err_o = this frame's flags.
  - rx_valid_o = 1.
  - If rx_valid_o was already 1 (and no rx_read_i this cycle): overrun_err_o = 1, and the new data overwrites the old.
- Read:
  - rx_read_i clears rx_valid_o, parity_err_o and frame_err_o on the next clk.
  - overrun_err_o clears only on rx_read_i when rx_valid_o=1.
  - COMPLETE and rx_read_i in the same clk: COMPLETE wins; valid stays 1; no overrun.
- Break condition (rx held low): yields data 0 and frame_err_o=1. The receiver then stays in IDLE until rx_s returns high, so a break produces no repeated frames.
- Config changes mid-frame have no effect until the next start.
- Reset asserted mid-frame aborts the frame with no outputs; rx_s = 1 for SYNC_STAGES clks after release.
- rx_data_o, rx_valid_o and all error outputs are registered. Latency from the final stop mid-sample tick to rx_valid_o=1 is 1 clk.

Decomposition:
- Shared package uart_pkg:
  - data-length encoding constants (DBITS_5..DBITS_8);
  - parity type constants (PAR_ODD=0, PAR_EVEN=1);
  - rx state enum typedef;
  - function num_data_bits(logic [1:0]) returning 5..8.
- Natural sub-module: uart_sync, a SYNC_STAGES-deep synchronizer with reset value 1, reusable for cts_n on the transmit side.

Test Plan:
- 8N1 at OVERSAMPLE=16, send 0xA5 -> rx_data_o=0xA5, rx_valid_o=1, no errors, rts_n=1. After rx_read_i: rx_valid_o=0, rts_n=0.
- 7E1 (bits=10, parity_en=1, type=1), send 0x35 with correct parity bit 0 -> data 0x35, parity_err_o=0. Repeat with parity bit 1 -> parity_err_o=1.
- 5-bit data, 2 stop bits, second stop bit driven 0, send 0x1F -> rx_data_o=0x1F, frame_err_o=1.
- rx low for 4 ticks then high (glitch) -> no START completion, rx_valid_o stays 0. Then send 0x3C -> rx_data_o=0x3C.
- Send 0x11 then 0x22 without reading -> rx_data_o=0x22, overrun_err_o=1. rx_read_i -> all flags 0.
- Back-to-back 8O1 frames at +3% baud skew, then assert rst mid-frame -> frames received correctly. After rst: all outputs are at reset values and the next frame is received cleanly.
